// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in/serial-out transmitter with valid/ready on both sides
module piso_shift_tx #(
    parameter int WIDTH = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic             O,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic             O_LAST
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic             w_shift;
    logic             w_end;
    assign w_shift = (r_state == SHIFT);
    assign w_end   = w_shift && (r_cnt == '0);
    // O_READY feeds I_READY combinationally so the next word loads on the last beat
    assign I_READY = !RESET && (!w_shift || (w_end && O_READY));
    assign O_VALID = w_shift;
    assign O_LAST  = w_end;
    assign O       = w_shift && (MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0]);
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else if (I_VALID && I_READY) begin
            r_state <= SHIFT;
            r_sr    <= I;
            r_cnt   <= CW'(WIDTH - 1);
        end else if (w_shift && O_READY) begin
            if (w_end) begin
                r_state <= IDLE;
            end else begin
                r_sr  <= MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: LSB-first and MSB-first transmitters against a bit-queue model
module tb_piso_shift_tx;
    logic       clk = 1'b0;
    logic       rst, i_valid, o_ready;
    logic [7:0] i_data;
    logic       o [2];
    logic       o_valid [2];
    logic       o_last [2];
    logic       i_ready [2];
    int         total = 0;
    int         bad = 0;
    bit         q [2][$];

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .CLK(clk), .RESET(rst), .I(i_data), .I_VALID(i_valid), .I_READY(i_ready[0]),
        .O(o[0]), .O_VALID(o_valid[0]), .O_READY(o_ready), .O_LAST(o_last[0]));
    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .CLK(clk), .RESET(rst), .I(i_data), .I_VALID(i_valid), .I_READY(i_ready[1]),
        .O(o[1]), .O_VALID(o_valid[1]), .O_READY(o_ready), .O_LAST(o_last[1]));

    // Each accepted word becomes 8 queued bits in send order; one pops per taken beat.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                q[d].delete();
            end else begin
                if (i_valid && (q[d].size() == 0 || (q[d].size() == 1 && o_ready))) begin
                    if (q[d].size() != 0) void'(q[d].pop_front());
                    for (int b = 0; b < 8; b++) q[d].push_back(d == 1 ? i_data[7-b] : i_data[b]);
                end else if (q[d].size() != 0 && o_ready) begin
                    void'(q[d].pop_front());
                end
            end
        end
    end

    task automatic chk(input string n, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b expected %b", n, $time, act, exp);
        end
    endtask

    task automatic check_model();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("o[%0d]", d), o[d], q[d].size() != 0 ? q[d][0] : 1'b0);
            chk($sformatf("o_valid[%0d]", d), o_valid[d], q[d].size() != 0);
            chk($sformatf("o_last[%0d]", d), o_last[d], q[d].size() == 1);
            chk($sformatf("i_ready[%0d]", d), i_ready[d],
                !rst && (q[d].size() == 0 || (q[d].size() == 1 && o_ready)));
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic rd);
        rst = r; i_valid = v; i_data = d; o_ready = rd;
        @(negedge clk);
        check_model();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] i;
        logic       eo, eov, eol, eir;
    } vec_t;
    vec_t tv [10];

    initial begin
        logic [7:0] a5 = 8'hA5;
        logic [7:0] msb_seq = 8'b10000001;
        rst = 1'b1; i_valid = 1'b0; i_data = '0; o_ready = 1'b1;
        @(posedge clk); #1;
        // reset held two cycles, then released
        step(1, 1, 8'h55, 1);
        step(0, 0, 8'h00, 1);
        // single word 0xA5, LSB first, against explicit expectations
        tv[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 1; k <= 8; k++) tv[k] = '{1'b0, 8'h00, a5[k-1], 1'b1, k == 8, k == 8};
        tv[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 10; k++) begin
            rst = 1'b0; i_valid = tv[k].iv; i_data = tv[k].i; o_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d o", k), o[0], tv[k].eo);
            chk($sformatf("vec%0d o_valid", k), o_valid[0], tv[k].eov);
            chk($sformatf("vec%0d o_last", k), o_last[0], tv[k].eol);
            chk($sformatf("vec%0d i_ready", k), i_ready[0], tv[k].eir);
            check_model();
            @(posedge clk); #1;
        end
        // MSB first, 0x81
        step(0, 1, 8'h81, 1);
        for (int k = 0; k < 8; k++) begin
            rst = 0; i_valid = 0; o_ready = 1;
            @(negedge clk);
            chk($sformatf("msb bit%0d", k), o[1], msb_seq[7-k]);
            chk($sformatf("msb last%0d", k), o_last[1], k == 7);
            @(posedge clk); #1;
        end
        step(0, 0, 8'h00, 1);
        // backpressure: stall 3 cycles after bit 2 of 0x0F, changing I meanwhile
        step(0, 1, 8'h0F, 1);
        step(0, 0, 8'hAA, 1);
        step(0, 0, 8'hAA, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 8'h33, 0);
        for (int k = 0; k < 7; k++) step(0, 0, 8'h00, 1);
        // back-to-back 0x01 then 0xFF with I_VALID held
        step(0, 1, 8'h01, 1);
        for (int k = 0; k < 8; k++) step(0, 1, 8'hFF, 1);
        for (int k = 0; k < 9; k++) step(0, 0, 8'h00, 1);
        // reset at the 4th bit of 0x3C, then 0xC3 intact
        step(0, 1, 8'h3C, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 8'h00, 1);
        step(1, 1, 8'h99, 1);
        step(0, 0, 8'h00, 1);
        step(0, 1, 8'hC3, 1);
        for (int k = 0; k < 9; k++) step(0, 0, 8'h00, 1);
        // randomized traffic with occasional reset
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, 8'($urandom),
                 $urandom_range(0, 3) != 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
